// File: rtl/eight_three_encoder_seq_pkg.sv
// Shared types and widths for the sequential 8-to-3 encoder.
package encoder_pkg;
   localparam int VEC_W  = 8;
   localparam int CODE_W = 3;
   localparam int CNT_W  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] popcount8(input logic [VEC_W-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < VEC_W; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/eight_three_encoder_seq_if.sv
// Request/beat handshake bundle between a producer and the encoder.
interface eight_three_encoder_seq_if;
   import encoder_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [VEC_W-1:0]  in_D;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_code;
   logic              out_last;
   logic              out_none;
   logic [CNT_W-1:0]  out_count;

   modport master (
      output in_valid, in_D, out_ready,
      input  in_ready, out_valid, out_code, out_last, out_none, out_count
   );

   modport slave (
      input  in_valid, in_D, out_ready,
      output in_ready, out_valid, out_code, out_last, out_none, out_count
   );
endinterface

// File: rtl/eight_three_encoder_seq_pri_find8.sv
// Combinational priority finder: selected index, its one-hot mask, and a
// flag for "exactly one bit set".
module pri_find8
   import encoder_pkg::*;
#(
   parameter bit HIGH_FIRST = 1'b0
) (
   input  logic [VEC_W-1:0]  vec,
   output logic [CODE_W-1:0] idx,
   output logic [VEC_W-1:0]  onehot,
   output logic              single
);
   logic found;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      if (!HIGH_FIRST) begin
         for (int i = 0; i < VEC_W; i++)
            if (vec[i] && !found) begin
               idx   = CODE_W'(i);
               found = 1'b1;
            end
      end else begin
         for (int i = VEC_W - 1; i >= 0; i--)
            if (vec[i] && !found) begin
               idx   = CODE_W'(i);
               found = 1'b1;
            end
      end
   end

   assign onehot = found ? (VEC_W'(1) << idx) : '0;
   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   assign single = (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);
endmodule

// File: rtl/eight_three_encoder_seq.sv
// Captures an 8-bit request vector and replays the index of each set bit,
// one per output handshake, in priority order.
module eight_three_encoder_seq
   import encoder_pkg::*;
#(
   parameter bit HIGH_FIRST = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   eight_three_encoder_seq_if.slave  bus
);
   state_e            state_q;
   logic [VEC_W-1:0]  pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              none_q;

   logic [CODE_W-1:0] sel_idx;
   logic [VEC_W-1:0]  sel_mask;
   logic              sel_single;
   logic              last;

   pri_find8 #(.HIGH_FIRST(HIGH_FIRST)) u_find (
      .vec    (pend_q),
      .idx    (sel_idx),
      .onehot (sel_mask),
      .single (sel_single)
   );

   assign last   = sel_single | none_q;
   assign pend_d = pend_q & ~sel_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         cnt_q   <= '0;
         none_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:
               if (bus.in_valid) begin
                  pend_q  <= bus.in_D;
                  cnt_q   <= popcount8(bus.in_D);
                  none_q  <= (bus.in_D == '0);
                  state_q <= ST_EMIT;
               end
            ST_EMIT:
               if (bus.out_ready) begin
                  pend_q <= pend_d;
                  if (last) state_q <= ST_IDLE;
               end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // in_ready follows rst_n so it drops the moment reset is asserted.
   assign bus.in_ready  = (state_q == ST_IDLE) && rst_n;
   assign bus.out_valid = (state_q == ST_EMIT);
   assign bus.out_code  = sel_idx;
   assign bus.out_last  = last;
   assign bus.out_none  = none_q;
   assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_eight_three_encoder_seq.sv
// Directed bench: a low-first and a high-first encoder share stimulus; each
// beat is compared against a bench-side index list and decoded back to a vector.
module tb_eight_three_encoder_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ntests = 0;
   int   nfail  = 0;

   eight_three_encoder_seq_if ifl ();
   eight_three_encoder_seq_if ifh ();

   eight_three_encoder_seq #(.HIGH_FIRST(1'b0)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(ifl));
   eight_three_encoder_seq #(.HIGH_FIRST(1'b1)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(ifh));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      int         cnt;
      int         first_lo;
      int         first_hi;
      int         stall_beat;
      int         stall_n;
      bit         hold;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input int act, input int exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [7:0] d);
      ifl.in_valid = v; ifl.in_D = d;
      ifh.in_valid = v; ifh.in_D = d;
   endtask

   task automatic set_ordy(input logic r);
      ifl.out_ready = r;
      ifh.out_ready = r;
   endtask

   function automatic logic [7:0] dec3to8(input logic [2:0] c);
      logic [7:0] one;
      one = 8'h01;
      return one << c;
   endfunction

   function automatic int pack_l();
      return int'({ifl.out_valid, ifl.out_code, ifl.out_last, ifl.out_none, ifl.out_count});
   endfunction

   function automatic int pack_h();
      return int'({ifh.out_valid, ifh.out_code, ifh.out_last, ifh.out_none, ifh.out_count});
   endfunction

   function automatic int pack_exp(input int code, input bit lst, input bit none, input int cnt);
      logic [9:0] p;
      p = {1'b1, 3'(code), lst, none, 4'(cnt)};
      return int'(p);
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!(ifl.in_ready && ifh.in_ready) && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", int'(ifl.in_ready && ifh.in_ready), 1);
   endtask

   task automatic run_vec(input logic [7:0] v, input int sb, input int sn, input bit hold,
                          input bit use_exp, input int e_cnt, input int e_lo, input int e_hi);
      int lo[8];
      int hi[8];
      int k, nb;
      logic [7:0] acc_l, acc_h;
      k = 0;
      for (int i = 0; i < 8; i++) if (v[i]) begin lo[k] = i; k++; end
      for (int j = 0; j < k; j++) hi[j] = lo[k-1-j];
      nb = (k == 0) ? 1 : k;
      if (k == 0) begin lo[0] = 0; hi[0] = 0; end
      acc_l = '0; acc_h = '0;

      wait_ready();
      set_in(1'b1, v);
      @(negedge clk);
      if (hold) set_in(1'b1, 8'hFF);
      else      set_in(1'b0, 8'($urandom));

      for (int b = 0; b < nb; b++) begin
         if (b == sb) begin
            set_ordy(1'b0);
            for (int s = 0; s < sn; s++) begin
               chk("stall_lo", pack_l(), pack_exp(lo[b], b == nb-1, k == 0, k));
               chk("stall_hi", pack_h(), pack_exp(hi[b], b == nb-1, k == 0, k));
               @(negedge clk);
            end
            set_ordy(1'b1);
         end
         chk("beat_lo", pack_l(), pack_exp(lo[b], b == nb-1, k == 0, k));
         chk("beat_hi", pack_h(), pack_exp(hi[b], b == nb-1, k == 0, k));
         chk("emit_in_ready", int'(ifl.in_ready | ifh.in_ready), 0);
         if (use_exp && b == 0) begin
            chk("tbl_count", int'(ifl.out_count), e_cnt);
            chk("tbl_first_lo", int'(ifl.out_code), e_lo);
            chk("tbl_first_hi", int'(ifh.out_code), e_hi);
         end
         if (!ifl.out_none) acc_l = acc_l | dec3to8(ifl.out_code);
         if (!ifh.out_none) acc_h = acc_h | dec3to8(ifh.out_code);
         @(negedge clk);
      end

      set_in(1'b0, 8'h00);
      chk("idle_gap_valid", int'(ifl.out_valid | ifh.out_valid), 0);
      chk("idle_in_ready", int'(ifl.in_ready & ifh.in_ready), 1);
      if (v != 8'h00) begin
         chk("roundtrip_lo", int'(acc_l), int'(v));
         chk("roundtrip_hi", int'(acc_h), int'(v));
      end
   endtask

   initial begin
      tbl[0] = '{8'h01, 1, 0, 0, -1, 0, 1'b0};
      tbl[1] = '{8'hA4, 3, 2, 7,  1, 3, 1'b0};
      tbl[2] = '{8'h00, 0, 0, 0, -1, 0, 1'b1};
      tbl[3] = '{8'hFF, 8, 0, 7,  4, 2, 1'b0};
      tbl[4] = '{8'h81, 2, 0, 7,  0, 1, 1'b1};
      tbl[5] = '{8'h10, 1, 4, 4, -1, 0, 1'b0};

      set_in(1'b0, 8'h00);
      set_ordy(1'b1);
      repeat (3) @(negedge clk);
      chk("reset_outputs", pack_l(), 0);
      chk("reset_in_ready", int'(ifl.in_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", int'(ifl.in_ready & ifh.in_ready), 1);
      chk("post_reset_valid", int'(ifl.out_valid | ifh.out_valid), 0);

      for (int t = 0; t < 5; t++)
         run_vec(tbl[t].d, tbl[t].stall_beat, tbl[t].stall_n, tbl[t].hold,
                 1'b1, tbl[t].cnt, tbl[t].first_lo, tbl[t].first_hi);

      // Reset asserted with one beat of 0110_0001 still pending.
      wait_ready();
      set_in(1'b1, 8'b0110_0001);
      @(negedge clk);
      set_in(1'b0, 8'h00);
      chk("mid_b0_lo", pack_l(), pack_exp(0, 1'b0, 1'b0, 3));
      chk("mid_b0_hi", pack_h(), pack_exp(6, 1'b0, 1'b0, 3));
      @(negedge clk);
      chk("mid_b1_lo", pack_l(), pack_exp(5, 1'b0, 1'b0, 3));
      @(negedge clk);
      chk("mid_b2_lo", pack_l(), pack_exp(6, 1'b1, 1'b0, 3));
      rst_n = 1'b0;
      #1;
      chk("async_rst_lo", pack_l(), 0);
      chk("async_rst_hi", pack_h(), 0);
      chk("async_rst_in_ready", int'(ifl.in_ready | ifh.in_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("no_beat_after_rst", int'(ifl.out_valid | ifh.out_valid), 0);
      end
      run_vec(tbl[5].d, tbl[5].stall_beat, tbl[5].stall_n, tbl[5].hold,
              1'b1, tbl[5].cnt, tbl[5].first_lo, tbl[5].first_hi);

      for (int v = 0; v < 256; v++)
         run_vec(8'(v), -1, 0, 1'b0, 1'b0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/eight_three_encoder_seq.md
Name: eight_three_encoder_seq

Overview:
Sequential 8-to-3 encoder: the inverse of the three_eight_decoder. It accepts an 8-bit request vector with a valid/ready handshake, then emits the 3-bit index of every set bit, one index per output handshake, in priority order. Each emitted code drives three_eight_decoder directly (bit2 = x, bit1 = y, bit0 = z), so a round trip reproduces a one-hot D.

Parameters:
HIGH_FIRST, 0, 0 = lowest set index emitted first; 1 = highest set index emitted first

Ports:
clk       input   1  rising-edge clock
rst_n     input   1  asynchronous active-low reset
in_valid  input   1  in_D is valid
in_ready  output  1  block can capture a vector (IDLE and rst_n high)
in_D      input   8  request vector, bit i = request for code i
out_valid output  1  out_code/out_last/out_none/out_count are valid
out_ready input   1  downstream accepts the current beat
out_code  output  3  index of the selected bit; bit2 = x, bit1 = y, bit0 = z
out_last  output  1  final beat for the captured vector
out_none  output  1  captured vector was all zeros (single beat, out_code = 0)
out_count output  4  popcount of the captured vector (0..8), constant for all beats of that vector

Behaviour:
- Only one clock is used. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n low, effective immediately): state = IDLE, pending register = 0, out_valid = 0, out_code = 0, out_last = 0, out_none = 0, out_count = 0, in_ready = 0. in_ready rises in the first cycle after rst_n is released.
- States: IDLE and EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Capture happens when in_valid && in_ready: pending <= in_D; out_count <= popcount(in_D); out_none <= (in_D == 0); state -> EMIT.
- Latency: a vector accepted at edge N gives out_valid = 1 from cycle N+1. All outputs are registered or decoded from registers only; there is no combinational path from in_* to out_*.
- EMIT:
  - in_ready = 0 and out_valid = 1; in_D and in_valid are ignored.
  - out_code = index of the lowest set bit of pending (highest if HIGH_FIRST = 1).
  - out_last = 1 when pending has exactly one bit set, or when out_none = 1.
- Beat transfer on out_valid && out_ready:
  - Clear the selected bit in pending.
  - If out_last: state -> IDLE, out_valid = 0 on the next cycle.
  - Otherwise: next code on the next cycle.
- Stall: while out_ready = 0, out_code, out_last, out_none and out_count hold stable.
- Zero vector: exactly one beat, with out_none = 1, out_code = 0, out_last = 1, out_count = 0.
- Throughput:
  - A vector with k set bits takes k beats (1 beat if k = 0).
  - There is a mandatory single IDLE cycle between vectors; no capture in the same cycle as the last beat.
- Reset mid-EMIT: the pending vector is discarded with no further beats, and outputs return to their reset values immediately.
- X on in_D when in_valid = 0 has no effect.

Decomposition:
- Package encoder_pkg: state encoding (ST_IDLE, ST_EMIT), VEC_W = 8, CODE_W = 3, CNT_W = 4.
- Sub-module pri_find8, purely combinational, with ports vec[7:0] and HIGH_FIRST parameter. Outputs: idx[2:0], onehot[7:0] (mask of the selected bit), single (popcount == 1).
- The top level holds the state register, pending register, count/none registers and handshake logic.

Test Plan:
1. Reset, then in_D = 8'b0000_0001 with out_ready = 1 -> one beat: code 0, last = 1, count = 1; in_ready returns to 1 two cycles after capture.
2. HIGH_FIRST = 0, in_D = 8'b1010_0100 -> beats with code 2, 5, 7; last only on 7; count = 3 on all beats. Hold out_ready = 0 for 3 cycles on the second beat -> code 5 stays stable and no beat is lost.
3. in_D = 8'h00 -> single beat: none = 1, code 0, last = 1, count = 0. in_valid held high during EMIT with in_D = 8'hFF -> ignored until IDLE.
4. in_D = 8'hFF -> 8 beats with codes 0..7 and count = 8. With HIGH_FIRST = 1, codes 7..0; last on the 8th beat only.
5. Drive rst_n low mid-EMIT after 2 of 3 beats of 8'b0110_0001 -> out_valid = 0 asynchronously, with no further beats after release. Then in_D = 8'h10 -> code 4.
6. Round trip: each emitted code drives three_eight_decoder x/y/z -> OR of all decoder D outputs equals the captured in_D, for all 256 vectors.
